pio_rx_fifo: RTL and testbench
==============================

Name: pio_rx_fifo

Overview:
- RX FIFO stage directly downstream of the state machine's input shift register (ISR).
- Accepts ISR contents on explicit PUSH or autopush, buffers them for the system bus, and generates the stall and ISR-clear handshakes back to the state machine.
- Supports FIFO join, which doubles depth by borrowing TX storage.

Parameters:
- WIDTH, 32, data word width (equal to the ISR width).
- DEPTH, 4, entries when not joined; capacity is 2*DEPTH when joined.

Ports:
- clk  input  1  single system clock.
- reset_n  input  1  asynchronous, active-low reset.
- penable  input  1  state-machine clock-enable pulse; gates all state-machine-side actions.
- join  input  1  1 = capacity 2*DEPTH.
- flush  input  1  synchronous clear of contents and pointers.
- push  input  1  explicit PUSH instruction this cycle.
- block  input  1  PUSH blocks (stalls) when full.
- push_data  input  WIDTH  ISR dout.
- isr_count  input  6  ISR shift_count, 0..32.
- thresh  input  5  autopush threshold; 0 means 32.
- autopush_en  input  1  autopush enable.
- pop  input  1  system read strobe.
- pop_data  output  WIDTH  head entry (show-ahead).
- empty  output  1  no entries.
- full  output  1  level == capacity.
- level  output  4  entry count, 0..2*DEPTH.
- stall  output  1  state machine must hold its current instruction.
- isr_clear  output  1  pulse: ISR must load 0 with bit_count 0.
- overflow  output  1  sticky; set on a dropped push.
- underflow  output  1  sticky; set on a pop while empty.
- clr_flags  input  1  clears both sticky flags.

Behaviour:
- Reset (reset_n low, async): pointers and level 0, overflow 0, underflow 0. Outputs settle to empty=1, full=0, stall=0, isr_clear=0, pop_data=0.
- Storage: 2*DEPTH x WIDTH register array. Write and read pointers are log2(2*DEPTH) bits and wrap modulo the current capacity (DEPTH or 2*DEPTH).
- Push request:
  - req = penable & (push | auto).
  - auto = autopush_en & !push & (isr_count >= thresh_val), where thresh_val = (thresh==0 ? 32 : thresh).
  - Autopush always behaves as blocking.
- Push outcome, decided combinationally each cycle:
  - Space available (level < capacity, or a pop occurs the same cycle while full): write push_data at wptr on the clock edge. Assert isr_clear; stall=0.
  - Full, blocking (block=1, or autopush): no write; stall=1; isr_clear=0. The state machine retries each penable cycle.
  - Full, explicit non-blocking push: data dropped; overflow<=1; isr_clear=1; stall=0.
- Pop:
  - pop & !empty: rptr advances and level decrements.
  - pop & empty: no change; underflow<=1.
  - A pop is not gated by penable.
- Simultaneous push and pop:
  - Level unchanged when both succeed.
  - When empty, the pop underflows while the push succeeds. The data pushed that cycle is visible on pop_data the next cycle.
- pop_data: mem[rptr], combinational from registered state. Driven to 0 when empty.
- Flags: latency zero. stall and isr_clear are combinational from the inputs and registered level. level, empty and full update one cycle after an accepted push or pop.
- Join change: any change of join (edge detected against a registered copy) flushes the FIFO exactly like flush=1. That cycle's push and pop are ignored and stall is forced to 1.
- flush: priority over push and pop. Clears level and pointers. Sticky flags are unaffected.
- clr_flags: lower priority than a setting event in the same cycle (set wins).
- penable=0: no push, no stall, no isr_clear. Pops still proceed.
- Reset asserted mid-push: contents are lost; all outputs return to their reset values asynchronously.

Decomposition:
- Shared pio package:
  - WIDTH and DEPTH defaults.
  - Threshold decode function (0 -> 32), shared with the ISR/OSR autopush/autopull logic.
  - Level width constant.
- One natural sub-module: pio_fifo_mem (parameterised register array with a write port and a show-ahead read port), reused later for the TX FIFO.

Test Plan:
- Basic order: reset, join=0; push 0x11,0x22,0x33,0x44 with penable=1 -> full=1 and level=4. Then 4 pops return 0x11..0x44 in order -> empty=1.
- Blocking full: fill 4 entries; push with block=1 -> stall=1, isr_clear=0, level stays 4. Pop in the same cycle -> push accepted, isr_clear=1, level stays 4.
- Non-blocking drop: full, push with block=0, data 0xDEAD -> overflow=1, isr_clear=1, 0xDEAD never popped. clr_flags -> overflow=0.
- Autopush: autopush_en=1, thresh=8, isr_count=8 -> isr_clear=1, entry written. thresh=0 with isr_count=31 -> no push; isr_count=32 -> push.
- Join: join=1; 8 pushes -> full only after the 8th, 8 pops in order. Toggle join with 3 entries held -> level=0 next cycle, stall=1 that cycle.
- Underflow/async reset: pop when empty -> underflow=1, level 0. Drop reset_n mid-stream -> level=0 and flags=0 immediately, without a clock edge.

Source files
------------

// File: rtl/pio_rx_fifo_pkg.sv
// Shared PIO definitions: default geometry, level width, push outcome
// encoding and the autopush/autopull threshold decode.
package pio_rx_fifo_pkg;

   localparam int PIO_WIDTH   = 32;
   localparam int PIO_DEPTH   = 4;
   localparam int LEVEL_W     = 4;
   localparam int ISR_COUNT_W = 6;

   // What happens to a push request in the current cycle.
   typedef enum logic [1:0] {
      PUSH_NONE,
      PUSH_WRITE,
      PUSH_STALL,
      PUSH_DROP
   } push_outcome_t;

   // A programmed threshold of 0 stands for a full 32-bit shift.
   function automatic logic [ISR_COUNT_W-1:0] thresh_decode(input logic [4:0] thresh);
      return (thresh == 5'd0) ? 6'd32 : {1'b0, thresh};
   endfunction

endpackage

// File: rtl/pio_fifo_mem.sv
// Register-array FIFO storage: one synchronous write port and one
// show-ahead (combinational) read port. Shared by the RX and TX FIFOs.
module pio_fifo_mem #(
   parameter int WIDTH   = 32,
   parameter int ENTRIES = 8,
   localparam int ADDR_W = $clog2(ENTRIES)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_data
);

   logic [WIDTH-1:0] mem [ENTRIES];

   // Entry write; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pio_rx_fifo.sv
// PIO RX FIFO: buffers ISR words pushed explicitly or by autopush, and
// returns stall / isr_clear handshakes to the state machine. Joining
// doubles the capacity by using the full 2*DEPTH storage array.
module pio_rx_fifo
   import pio_rx_fifo_pkg::*;
#(
   parameter int WIDTH = PIO_WIDTH,
   parameter int DEPTH = PIO_DEPTH
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   penable,
   input  logic                   fifo_join,
   input  logic                   flush,
   input  logic                   push,
   input  logic                   block,
   input  logic [WIDTH-1:0]       push_data,
   input  logic [ISR_COUNT_W-1:0] isr_count,
   input  logic [4:0]             thresh,
   input  logic                   autopush_en,
   input  logic                   pop,
   output logic [WIDTH-1:0]       pop_data,
   output logic                   empty,
   output logic                   full,
   output logic [LEVEL_W-1:0]     level,
   output logic                   stall,
   output logic                   isr_clear,
   output logic                   overflow,
   output logic                   underflow,
   input  logic                   clr_flags
);

   localparam int PTR_W = $clog2(2*DEPTH);
   localparam logic [LEVEL_W-1:0] CAP_SINGLE  = LEVEL_W'(DEPTH);
   localparam logic [LEVEL_W-1:0] CAP_JOINED  = LEVEL_W'(2*DEPTH);
   localparam logic [PTR_W-1:0]   LAST_SINGLE = PTR_W'(DEPTH-1);
   localparam logic [PTR_W-1:0]   LAST_JOINED = PTR_W'(2*DEPTH-1);

   logic [PTR_W-1:0]   wptr_reg, wptr_next;
   logic [PTR_W-1:0]   rptr_reg, rptr_next;
   logic [LEVEL_W-1:0] level_reg, level_next;
   logic               overflow_reg, overflow_next;
   logic               underflow_reg, underflow_next;
   logic               join_reg;

   logic [LEVEL_W-1:0] capacity;
   logic [PTR_W-1:0]   ptr_last;
   logic               is_empty;
   logic               is_full;
   logic               join_change;
   logic               clear_all;
   logic               auto_req;
   logic               push_req;
   logic               pop_ok;
   logic               pop_under;
   logic               wr_en;
   logic [WIDTH-1:0]   rd_data;
   push_outcome_t      outcome;

   // Pointers wrap at the active capacity, not at the array size.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p,
                                                input logic [PTR_W-1:0] last);
      return (p == last) ? '0 : p + 1'b1;
   endfunction

   assign capacity    = join_reg ? CAP_JOINED : CAP_SINGLE;
   assign ptr_last    = join_reg ? LAST_JOINED : LAST_SINGLE;
   assign is_empty    = (level_reg == '0);
   assign is_full     = (level_reg == capacity);
   assign join_change = fifo_join ^ join_reg;
   assign clear_all   = flush | join_change;
   assign auto_req    = autopush_en & ~push & (isr_count >= thresh_decode(thresh));
   assign push_req    = penable & (push | auto_req) & ~clear_all;
   assign pop_ok      = pop & ~is_empty & ~clear_all;
   assign pop_under   = pop & is_empty & ~clear_all;

   // Classify the push request; a same-cycle pop frees a slot when full.
   always_comb begin
      outcome = PUSH_NONE;
      if (push_req) begin
         if (!is_full || pop_ok) begin
            outcome = PUSH_WRITE;
         end else if (block || auto_req) begin
            outcome = PUSH_STALL;
         end else begin
            outcome = PUSH_DROP;
         end
      end
   end

   assign wr_en     = (outcome == PUSH_WRITE);
   assign isr_clear = (outcome == PUSH_WRITE) || (outcome == PUSH_DROP);
   assign stall     = join_change || (outcome == PUSH_STALL);

   // Next pointers, level and sticky flags; a set event beats clr_flags.
   always_comb begin
      wptr_next      = wptr_reg;
      rptr_next      = rptr_reg;
      level_next     = level_reg;
      overflow_next  = overflow_reg;
      underflow_next = underflow_reg;

      if (clear_all) begin
         wptr_next  = '0;
         rptr_next  = '0;
         level_next = '0;
      end else begin
         if (wr_en) begin
            wptr_next = ptr_inc(wptr_reg, ptr_last);
         end
         if (pop_ok) begin
            rptr_next = ptr_inc(rptr_reg, ptr_last);
         end
         if (wr_en && !pop_ok) begin
            level_next = level_reg + 1'b1;
         end else if (!wr_en && pop_ok) begin
            level_next = level_reg - 1'b1;
         end
      end

      if (clr_flags) begin
         overflow_next  = 1'b0;
         underflow_next = 1'b0;
      end
      if (outcome == PUSH_DROP) begin
         overflow_next = 1'b1;
      end
      if (pop_under) begin
         underflow_next = 1'b1;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wptr_reg      <= '0;
         rptr_reg      <= '0;
         level_reg     <= '0;
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
         join_reg      <= 1'b0;
      end else begin
         wptr_reg      <= wptr_next;
         rptr_reg      <= rptr_next;
         level_reg     <= level_next;
         overflow_reg  <= overflow_next;
         underflow_reg <= underflow_next;
         join_reg      <= fifo_join;
      end
   end

   pio_fifo_mem #(
      .WIDTH   (WIDTH),
      .ENTRIES (2*DEPTH)
   ) u_mem (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wptr_reg),
      .wr_data (push_data),
      .rd_addr (rptr_reg),
      .rd_data (rd_data)
   );

   assign pop_data  = is_empty ? '0 : rd_data;
   assign empty     = is_empty;
   assign full      = is_full;
   assign level     = level_reg;
   assign overflow  = overflow_reg;
   assign underflow = underflow_reg;

endmodule

// File: tb/tb_pio_rx_fifo.sv
// Self-checking bench for pio_rx_fifo: directed scenarios plus a
// randomized run, all checked against a queue-based reference model.
module tb_pio_rx_fifo;

   logic        clk;
   logic        reset_n;
   logic        penable;
   logic        fifo_join;
   logic        flush;
   logic        push;
   logic        block;
   logic [31:0] push_data;
   logic [5:0]  isr_count;
   logic [4:0]  thresh;
   logic        autopush_en;
   logic        pop;
   logic        clr_flags;
   logic [31:0] pop_data;
   logic        empty;
   logic        full;
   logic [3:0]  level;
   logic        stall;
   logic        isr_clear;
   logic        overflow;
   logic        underflow;

   int checks   = 0;
   int failures = 0;

   pio_rx_fifo #(.WIDTH(32), .DEPTH(4)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .penable     (penable),
      .fifo_join   (fifo_join),
      .flush       (flush),
      .push        (push),
      .block       (block),
      .push_data   (push_data),
      .isr_count   (isr_count),
      .thresh      (thresh),
      .autopush_en (autopush_en),
      .pop         (pop),
      .pop_data    (pop_data),
      .empty       (empty),
      .full        (full),
      .level       (level),
      .stall       (stall),
      .isr_clear   (isr_clear),
      .overflow    (overflow),
      .underflow   (underflow),
      .clr_flags   (clr_flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [31:0] q[$];
   bit          m_ovf, m_unf, m_join_prev;
   bit          exp_stall, exp_isr_clear;
   bit          p_accept, p_drop, p_popok, p_unf, p_clr;
   logic [31:0] p_data;
   logic        obs_stall, obs_isr_clear;

   function automatic int m_cap();
      return m_join_prev ? 8 : 4;
   endfunction

   function automatic logic [31:0] m_head();
      return (q.size() > 0) ? q[0] : 32'h0;
   endfunction

   task automatic model_reset();
      q.delete();
      m_ovf = 0;
      m_unf = 0;
      m_join_prev = 0;
   endtask

   task automatic model_predict();
      int tv;
      bit auto_r, req;
      p_clr   = flush || (fifo_join != m_join_prev);
      tv      = (thresh == 0) ? 32 : int'(thresh);
      auto_r  = autopush_en && !push && (int'(isr_count) >= tv);
      req     = penable && (push || auto_r) && !p_clr;
      p_popok = pop && (q.size() > 0) && !p_clr;
      p_unf   = pop && (q.size() == 0) && !p_clr;
      p_accept  = 0;
      p_drop    = 0;
      p_data    = push_data;
      exp_stall = (fifo_join != m_join_prev);
      if (req) begin
         if (q.size() < m_cap() || p_popok) p_accept = 1;
         else if (block || !push)           exp_stall = 1;
         else                               p_drop = 1;
      end
      exp_isr_clear = p_accept || p_drop;
   endtask

   task automatic model_commit();
      if (p_clr) begin
         q.delete();
      end else begin
         if (p_popok)  void'(q.pop_front());
         if (p_accept) q.push_back(p_data);
      end
      if (p_drop) m_ovf = 1;
      else if (clr_flags) m_ovf = 0;
      if (p_unf) m_unf = 1;
      else if (clr_flags) m_unf = 0;
      m_join_prev = fifo_join;
   endtask

   // One clock: predict + sample combinational handshakes, then commit.
   task automatic tick();
      @(negedge clk);
      model_predict();
      obs_stall     = stall;
      obs_isr_clear = isr_clear;
      @(posedge clk);
      model_commit();
      #1;
   endtask

   task automatic set_idle();
      penable     = 1'b0;
      flush       = 1'b0;
      push        = 1'b0;
      block       = 1'b0;
      push_data   = 32'h0;
      isr_count   = 6'd0;
      thresh      = 5'd0;
      autopush_en = 1'b0;
      pop         = 1'b0;
      clr_flags   = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      set_idle();
      fifo_join = 1'b0;
      reset_n   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
      checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
      checks++; if (level !== 4'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
      checks++; if (stall !== 1'b0 || isr_clear !== 1'b0) begin failures++; $display("FAIL reset_handshake stall=%b isr_clear=%b exp=0/0", stall, isr_clear); end
      checks++; if (pop_data !== 32'h0) begin failures++; $display("FAIL reset_pop_data got=%h exp=0", pop_data); end
      checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin failures++; $display("FAIL reset_flags ovf=%b unf=%b exp=0/0", overflow, underflow); end
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      $display("test_reset done");
   endtask

   task automatic test_basic_order();
      logic [31:0] vals [4];
      vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33; vals[3] = 32'h44;
      for (int i = 0; i < 4; i++) begin
         set_idle();
         penable = 1; push = 1; push_data = vals[i];
         tick();
         checks++; if (obs_isr_clear !== 1'b1) begin failures++; $display("FAIL basic_push_clear[%0d] got=%b exp=1", i, obs_isr_clear); end
      end
      set_idle();
      checks++; if (full !== 1'b1 || level !== 4'd4) begin failures++; $display("FAIL basic_full full=%b level=%0d exp=1/4", full, level); end
      for (int i = 0; i < 4; i++) begin
         set_idle();
         pop = 1;
         checks++; if (pop_data !== vals[i]) begin failures++; $display("FAIL basic_pop[%0d] got=%h exp=%h", i, pop_data, vals[i]); end
         tick();
      end
      set_idle();
      checks++; if (empty !== 1'b1 || level !== 4'd0) begin failures++; $display("FAIL basic_empty empty=%b level=%0d exp=1/0", empty, level); end
      $display("test_basic_order done");
   endtask

   task automatic test_blocking_full();
      int guard;
      for (int i = 0; i < 4; i++) begin
         set_idle(); penable = 1; push = 1; push_data = $urandom; tick();
      end
      set_idle(); penable = 1; push = 1; block = 1; push_data = 32'hB10C_0001;
      tick();
      checks++; if (obs_stall !== 1'b1 || obs_isr_clear !== 1'b0) begin failures++; $display("FAIL block_stall stall=%b isr_clear=%b exp=1/0", obs_stall, obs_isr_clear); end
      checks++; if (level !== 4'd4) begin failures++; $display("FAIL block_level got=%0d exp=4", level); end
      pop = 1;
      tick();
      checks++; if (obs_stall !== 1'b0 || obs_isr_clear !== 1'b1) begin failures++; $display("FAIL block_pop_push stall=%b isr_clear=%b exp=0/1", obs_stall, obs_isr_clear); end
      checks++; if (level !== 4'd4) begin failures++; $display("FAIL block_pop_level got=%0d exp=4", level); end
      set_idle(); pop = 1;
      guard = 0;
      while (q.size() > 0 && guard < 16) begin
         checks++; if (pop_data !== m_head()) begin failures++; $display("FAIL block_drain got=%h exp=%h", pop_data, m_head()); end
         tick();
         guard++;
      end
      set_idle();
      $display("test_blocking_full done");
   endtask

   task automatic test_nonblocking_drop();
      int guard;
      for (int i = 0; i < 4; i++) begin
         set_idle(); penable = 1; push = 1; push_data = 32'h100 + 32'(i); tick();
      end
      set_idle(); penable = 1; push = 1; block = 0; push_data = 32'hDEAD;
      tick();
      checks++; if (obs_isr_clear !== 1'b1 || obs_stall !== 1'b0) begin failures++; $display("FAIL drop_handshake isr_clear=%b stall=%b exp=1/0", obs_isr_clear, obs_stall); end
      checks++; if (overflow !== 1'b1 || level !== 4'd4) begin failures++; $display("FAIL drop_overflow ovf=%b level=%0d exp=1/4", overflow, level); end
      set_idle(); pop = 1;
      guard = 0;
      while (q.size() > 0 && guard < 16) begin
         checks++; if (pop_data === 32'hDEAD || pop_data !== m_head()) begin failures++; $display("FAIL drop_drain got=%h exp=%h", pop_data, m_head()); end
         tick();
         guard++;
      end
      set_idle(); clr_flags = 1;
      tick();
      set_idle();
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL drop_clr_flags got=%b exp=0", overflow); end
      $display("test_nonblocking_drop done");
   endtask

   task automatic test_autopush();
      set_idle(); penable = 1; autopush_en = 1; thresh = 5'd8; isr_count = 6'd8; push_data = 32'hA0A0_0008;
      tick();
      checks++; if (obs_isr_clear !== 1'b1 || level !== 4'd1) begin failures++; $display("FAIL auto_thresh8 isr_clear=%b level=%0d exp=1/1", obs_isr_clear, level); end
      thresh = 5'd0; isr_count = 6'd31;
      tick();
      checks++; if (obs_isr_clear !== 1'b0 || level !== 4'd1) begin failures++; $display("FAIL auto_thresh0_31 isr_clear=%b level=%0d exp=0/1", obs_isr_clear, level); end
      isr_count = 6'd32; push_data = 32'hA0A0_0020;
      tick();
      checks++; if (obs_isr_clear !== 1'b1 || level !== 4'd2) begin failures++; $display("FAIL auto_thresh0_32 isr_clear=%b level=%0d exp=1/2", obs_isr_clear, level); end
      tick(); tick();
      block = 0;
      tick();
      checks++; if (obs_stall !== 1'b1 || obs_isr_clear !== 1'b0 || level !== 4'd4) begin failures++; $display("FAIL auto_full_stall stall=%b isr_clear=%b level=%0d exp=1/0/4", obs_stall, obs_isr_clear, level); end
      set_idle(); pop = 1;
      checks++; if (pop_data !== 32'hA0A0_0008) begin failures++; $display("FAIL auto_head got=%h exp=a0a00008", pop_data); end
      for (int i = 0; i < 4; i++) tick();
      set_idle();
      $display("test_autopush done");
   endtask

   task automatic test_join();
      logic [31:0] vals [8];
      set_idle(); fifo_join = 1;
      tick();
      checks++; if (obs_stall !== 1'b1) begin failures++; $display("FAIL join_enter_stall got=%b exp=1", obs_stall); end
      for (int i = 0; i < 8; i++) begin
         vals[i] = $urandom;
         set_idle(); penable = 1; push = 1; push_data = vals[i];
         tick();
         checks++; if (full !== (i == 7)) begin failures++; $display("FAIL join_full[%0d] got=%b exp=%b", i, full, (i == 7)); end
      end
      for (int i = 0; i < 8; i++) begin
         set_idle(); pop = 1;
         checks++; if (pop_data !== vals[i]) begin failures++; $display("FAIL join_pop[%0d] got=%h exp=%h", i, pop_data, vals[i]); end
         tick();
      end
      for (int i = 0; i < 3; i++) begin
         set_idle(); penable = 1; push = 1; push_data = $urandom; tick();
      end
      set_idle(); penable = 1; push = 1; push_data = 32'h5A5A; fifo_join = 0;
      tick();
      checks++; if (obs_stall !== 1'b1 || obs_isr_clear !== 1'b0) begin failures++; $display("FAIL join_toggle_stall stall=%b isr_clear=%b exp=1/0", obs_stall, obs_isr_clear); end
      checks++; if (level !== 4'd0 || empty !== 1'b1) begin failures++; $display("FAIL join_toggle_flush level=%0d empty=%b exp=0/1", level, empty); end
      set_idle();
      $display("test_join done");
   endtask

   task automatic test_underflow_async_reset();
      set_idle(); pop = 1;
      tick();
      checks++; if (underflow !== 1'b1 || level !== 4'd0) begin failures++; $display("FAIL underflow unf=%b level=%0d exp=1/0", underflow, level); end
      set_idle(); pop = 1; penable = 1; push = 1; push_data = 32'hC0DE_0001;
      tick();
      checks++; if (level !== 4'd1 || pop_data !== 32'hC0DE_0001) begin failures++; $display("FAIL empty_push_pop level=%0d data=%h exp=1/c0de0001", level, pop_data); end
      set_idle(); penable = 1; push = 1; push_data = 32'hC0DE_0002; block = 0;
      tick(); tick(); tick(); tick();
      checks++; if (overflow !== 1'b1 || level !== 4'd4) begin failures++; $display("FAIL pre_reset ovf=%b level=%0d exp=1/4", overflow, level); end
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      checks++; if (level !== 4'd0 || empty !== 1'b1 || pop_data !== 32'h0) begin failures++; $display("FAIL async_reset level=%0d empty=%b data=%h exp=0/1/0", level, empty, pop_data); end
      checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin failures++; $display("FAIL async_reset_flags ovf=%b unf=%b exp=0/0", overflow, underflow); end
      set_idle();
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      $display("test_underflow_async_reset done");
   endtask

   task automatic test_random();
      int errs_before;
      errs_before = failures;
      for (int n = 0; n < 400; n++) begin
         penable     = ($urandom_range(0, 3) != 0);
         push        = ($urandom_range(0, 9) < 4);
         block       = $urandom_range(0, 1);
         push_data   = $urandom;
         autopush_en = $urandom_range(0, 1);
         isr_count   = 6'($urandom_range(0, 32));
         thresh      = 5'($urandom_range(0, 31));
         pop         = ($urandom_range(0, 9) < 4);
         flush       = ($urandom_range(0, 39) == 0);
         clr_flags   = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 59) == 0) fifo_join = ~fifo_join;
         checks++; if (pop_data !== m_head()) begin failures++; $display("FAIL rand_pop_data[%0d] got=%h exp=%h", n, pop_data, m_head()); end
         tick();
         checks++; if (obs_stall !== exp_stall || obs_isr_clear !== exp_isr_clear) begin failures++; $display("FAIL rand_handshake[%0d] stall=%b isr_clear=%b exp=%b/%b", n, obs_stall, obs_isr_clear, exp_stall, exp_isr_clear); end
         checks++; if (level !== 4'(q.size()) || empty !== (q.size() == 0) || full !== (q.size() == m_cap())) begin failures++; $display("FAIL rand_level[%0d] level=%0d empty=%b full=%b exp_level=%0d", n, level, empty, full, q.size()); end
         checks++; if (overflow !== m_ovf || underflow !== m_unf) begin failures++; $display("FAIL rand_flags[%0d] ovf=%b unf=%b exp=%b/%b", n, overflow, underflow, m_ovf, m_unf); end
      end
      set_idle();
      $display("test_random done errors=%0d", failures - errs_before);
   endtask

   initial begin
      test_reset();
      test_basic_order();
      test_blocking_full();
      test_nonblocking_drop();
      test_autopush();
      test_join();
      test_underflow_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
